// File: rtl/pu_layer_scheduler.sv
// -----------------------------------------------------------------------------
// pu_layer_scheduler
//
// Top-level layer sequencer for the processing-unit (PU) array. A run walks
// layers 0..num_layers-1. For each layer it reads that layer's config word
// from the layer-config RAM, sends a one-cycle start pulse to the PUs enabled
// by the word's low NUM_PU bits, and waits until every enabled PU has reported
// done. Then it moves to the next layer. A one-cycle done pulse marks the end
// of the run.
//
// Parameters
//   LAYER_PARAM_WIDTH  width of layer count / layer index / config address
//   NUM_PU             number of PUs sequenced
//   CFG_WIDTH          layer config word width (must be >= NUM_PU)
//
// Ports
//   i_clk             clock, rising edge
//   i_reset           asynchronous active-high reset
//   i_start           begin a run (sampled in IDLE only)
//   i_abort           cancel the run and return to IDLE (highest priority)
//   i_cfg_num_layers  number of layers in the run, latched on start
//   o_cfg_rd_en       config RAM read strobe
//   o_cfg_rd_addr     config RAM address (the current layer index)
//   i_cfg_rd_data     config word, valid one cycle after o_cfg_rd_en
//   o_layer_cfg       captured config word of the current layer
//   o_pu_start        per-PU one-cycle start pulse
//   i_pu_done         per-PU done pulse (any width >= 1 cycle)
//   o_layer_idx       current layer index
//   o_busy            high in every state except IDLE
//   o_done            one-cycle pulse when a run completes
//   o_state           current FSM state (debug)
// -----------------------------------------------------------------------------
module pu_layer_scheduler #(
    parameter int unsigned LAYER_PARAM_WIDTH = 10,
    parameter int unsigned NUM_PU            = 4,
    parameter int unsigned CFG_WIDTH         = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic [LAYER_PARAM_WIDTH-1:0] i_cfg_num_layers,
    output logic                         o_cfg_rd_en,
    output logic [LAYER_PARAM_WIDTH-1:0] o_cfg_rd_addr,
    input  logic [CFG_WIDTH-1:0]         i_cfg_rd_data,
    output logic [CFG_WIDTH-1:0]         o_layer_cfg,
    output logic [NUM_PU-1:0]            o_pu_start,
    input  logic [NUM_PU-1:0]            i_pu_done,
    output logic [LAYER_PARAM_WIDTH-1:0] o_layer_idx,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [2:0]                   o_state
);

    // -------------------------------------------------------------------------
    // State encoding. Software reads these values back through o_state.
    // -------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_CAP   = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_NEXT  = 3'd5;
    localparam logic [2:0] ST_FIN   = 3'd6;

    localparam logic [LAYER_PARAM_WIDTH-1:0] LAYER_ONE = LAYER_PARAM_WIDTH'(1);

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    logic [1:0]                   r_rst_sync;
    logic                         w_rst;

    logic [2:0]                   r_state;
    logic [2:0]                   w_state_nxt;

    logic [LAYER_PARAM_WIDTH-1:0] r_num_layers;
    logic [LAYER_PARAM_WIDTH-1:0] r_layer_idx;
    logic [CFG_WIDTH-1:0]         r_layer_cfg;
    logic [NUM_PU-1:0]            r_done_seen;

    logic [NUM_PU-1:0]            w_mask;
    logic                         w_mask_zero;
    logic                         w_all_done;
    logic                         w_last_layer;
    logic                         w_run_empty;

    // -------------------------------------------------------------------------
    // Reset synchroniser.
    // Reset asserts asynchronously. Release is delayed by two clock edges so
    // that every flop leaves reset on the same edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

    // -------------------------------------------------------------------------
    // Layer bookkeeping decodes
    // -------------------------------------------------------------------------
    assign w_mask      = r_layer_cfg[NUM_PU-1:0];
    assign w_mask_zero = (w_mask == '0);

    // Include the done bits of the current cycle so that the last required
    // done pulse moves the FSM on at the next edge. Done bits from PUs outside
    // the mask are dropped.
    assign w_all_done   = (((r_done_seen | i_pu_done) & w_mask) == w_mask);
    assign w_last_layer = (r_layer_idx == (r_num_layers - LAYER_ONE));
    assign w_run_empty  = (i_cfg_num_layers == '0);

    // -------------------------------------------------------------------------
    // Next-state logic. Abort overrides every transition.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_state_nxt = w_run_empty ? ST_FIN : ST_RD;
                    end
                end
                ST_RD:    w_state_nxt = ST_CAP;
                ST_CAP:   w_state_nxt = ST_ISSUE;
                ST_ISSUE: w_state_nxt = w_mask_zero ? ST_NEXT : ST_WAIT;
                ST_WAIT: begin
                    if (w_all_done) begin
                        w_state_nxt = ST_NEXT;
                    end
                end
                ST_NEXT:  w_state_nxt = w_last_layer ? ST_FIN : ST_RD;
                ST_FIN:   w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers.
    // On abort all of these hold their values. layer_idx and layer_cfg then
    // still show where the run stopped.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            r_num_layers <= '0;
            r_layer_idx  <= '0;
            r_layer_cfg  <= '0;
            r_done_seen  <= '0;
        end else if (!i_abort) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_num_layers <= i_cfg_num_layers;
                        r_layer_idx  <= '0;
                    end
                end
                ST_CAP: begin
                    r_layer_cfg <= i_cfg_rd_data;
                    r_done_seen <= '0;
                end
                ST_WAIT: begin
                    r_done_seen <= r_done_seen | (i_pu_done & w_mask);
                end
                ST_NEXT: begin
                    if (!w_last_layer) begin
                        r_layer_idx <= r_layer_idx + LAYER_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs.
    // Strobes are decoded from the state register. They are gated by abort so
    // that no read, start or done can escape in the cycle that abort arrives.
    // -------------------------------------------------------------------------
    always_comb begin
        o_cfg_rd_en   = 1'b0;
        o_cfg_rd_addr = '0;
        o_pu_start    = '0;
        o_done        = 1'b0;
        if (!i_abort) begin
            case (r_state)
                ST_RD: begin
                    o_cfg_rd_en   = 1'b1;
                    o_cfg_rd_addr = r_layer_idx;
                end
                ST_ISSUE: o_pu_start = w_mask;
                ST_FIN:   o_done     = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state != ST_IDLE);
    assign o_state     = r_state;
    assign o_layer_idx = r_layer_idx;
    assign o_layer_cfg = r_layer_cfg;

endmodule

// File: tb/tb_pu_layer_scheduler.sv
module tb_pu_layer_scheduler;

    localparam int LPW  = 10;
    localparam int NPU  = 4;
    localparam int CW   = 32;
    localparam int CMAX = 256;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [LPW-1:0] num_layers;
    logic           rd_en;
    logic [LPW-1:0] rd_addr;
    logic [CW-1:0]  rd_data;
    logic [CW-1:0]  layer_cfg;
    logic [NPU-1:0] pu_start;
    logic [NPU-1:0] pu_done;
    logic [LPW-1:0] layer_idx;
    logic           busy;
    logic           done;
    logic [2:0]     state;

    always #5 clk = ~clk;

    pu_layer_scheduler #(
        .LAYER_PARAM_WIDTH(LPW),
        .NUM_PU           (NPU),
        .CFG_WIDTH        (CW)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_start         (start),
        .i_abort         (abort),
        .i_cfg_num_layers(num_layers),
        .o_cfg_rd_en     (rd_en),
        .o_cfg_rd_addr   (rd_addr),
        .i_cfg_rd_data   (rd_data),
        .o_layer_cfg     (layer_cfg),
        .o_pu_start      (pu_start),
        .i_pu_done       (pu_done),
        .o_layer_idx     (layer_idx),
        .o_busy          (busy),
        .o_done          (done),
        .o_state         (state)
    );

    // Expected per-cycle timeline of one run (cycle 0 = the cycle start is high)
    logic        e_rd   [CMAX];
    int          e_addr [CMAX];
    logic [3:0]  e_pst  [CMAX];
    logic        e_done [CMAX];
    logic        e_busy [CMAX];
    int          e_state[CMAX];
    int          e_lidx [CMAX];
    logic [31:0] e_cfg  [CMAX];
    // Stimulus driven per cycle
    logic [3:0]  d_done [CMAX];
    logic        d_dv   [CMAX];
    logic [31:0] d_data [CMAX];

    logic [31:0] cfg_mem[16];
    int          iss_at [16];
    int          fin;
    logic [31:0] last_cfg;
    int          last_lidx;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          stagger[4] = '{1, 3, 2, 4};  // bit0,bit2,bit1,bit3 order

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_mem(input int l, input logic [3:0] mask);
        logic [31:0] w;
        w       = $urandom();
        w[3:0]  = mask;
        cfg_mem[l] = w;
    endtask

    // Build the expected timeline from the sequencing rules:
    // RD at t, data valid at t+1, ISSUE at t+2; a layer ends when every enabled
    // PU has pulsed done after ISSUE; then NEXT, then RD or FIN.
    // mode 0: all PUs done 5 cycles after start; 1: random; 2: staggered order.
    task automatic build(input int n, input int mode);
        int          t, iss, comp, d, dmax, nxt, fill_c;
        logic [3:0]  m;
        logic [31:0] cur_cfg;
        for (int c = 0; c < CMAX; c++) begin
            e_rd[c] = 0; e_addr[c] = 0; e_pst[c] = 0; e_done[c] = 0; e_busy[c] = 0;
            e_state[c] = 0; e_lidx[c] = 0; d_done[c] = 0; d_dv[c] = 0; d_data[c] = 0;
        end
        cur_cfg = last_cfg;
        fill_c  = 0;
        t       = 1;
        for (int l = 0; l < n; l++) begin
            e_rd[t] = 1; e_addr[t] = l; e_state[t] = 1;
            d_dv[t+1] = 1; d_data[t+1] = cfg_mem[l]; e_state[t+1] = 2;
            for (int c = fill_c; c <= t + 1; c++) e_cfg[c] = cur_cfg;
            cur_cfg = cfg_mem[l];
            fill_c  = t + 2;
            iss = t + 2;
            iss_at[l] = iss;
            e_state[iss] = 3;
            m = cfg_mem[l][3:0];
            if (m == 4'h0) begin
                e_state[iss+1] = 5;
                nxt = iss + 2;
            end else begin
                e_pst[iss] = m;
                if (mode == 1) d_done[iss] = 4'($urandom());  // same cycle as start: ignored
                dmax = 0;
                for (int i = 0; i < 4; i++) begin
                    if (m[i]) begin
                        if (mode == 0)      d = 5;
                        else if (mode == 1) d = $urandom_range(1, 6);
                        else                d = stagger[i];
                        d_done[iss+d][i] = 1'b1;
                        if (mode == 1 && $urandom_range(0, 1) == 1) d_done[iss+d+1][i] = 1'b1;
                        if (d > dmax) dmax = d;
                    end
                end
                comp = iss + dmax;
                if (mode == 1) begin
                    for (int c = iss + 1; c < comp; c++) d_done[c] = d_done[c] | (4'($urandom()) & ~m);
                end
                if (mode == 2) begin
                    d_done[iss+2][0] = 1'b1;
                    d_done[iss+3][0] = 1'b1;
                end
                for (int c = iss + 1; c <= comp; c++) e_state[c] = 4;
                e_state[comp+1] = 5;
                nxt = comp + 2;
            end
            for (int c = t; c < nxt; c++) e_lidx[c] = l;
            t = nxt;
        end
        fin = t;
        e_done[fin]  = 1;
        e_state[fin] = 6;
        for (int c = 1; c <= fin; c++) e_busy[c] = 1;
        for (int c = fin; c < CMAX; c++) e_lidx[c] = (n == 0) ? 0 : n - 1;
        for (int c = fill_c; c < CMAX; c++) e_cfg[c] = cur_cfg;
    endtask

    task automatic apply_abort(input int a);
        for (int c = a; c < CMAX; c++) begin
            e_rd[c] = 0; e_addr[c] = 0; e_pst[c] = 0; e_done[c] = 0;
            if (c > a) begin
                e_busy[c] = 0; e_state[c] = 0; d_done[c] = 0;
                e_lidx[c] = e_lidx[a]; e_cfg[c] = e_cfg[a];
            end
        end
    endtask

    task automatic execute(input int n, input int len, input int abort_at, input bit noise);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            start = (c == 0) || (noise && c <= fin && (abort_at < 0 || c <= abort_at) &&
                                 $urandom_range(0, 2) == 0);
            abort      = (c == abort_at);
            num_layers = (c == 0) ? LPW'(n) : LPW'($urandom());
            rd_data    = d_dv[c] ? d_data[c] : $urandom();
            pu_done    = d_done[c];
            #1;
            check($sformatf("rd_en c%0d", c),    rd_en,    e_rd[c]);
            check($sformatf("rd_addr c%0d", c),  rd_addr,  e_addr[c]);
            check($sformatf("pu_start c%0d", c), pu_start, e_pst[c]);
            check($sformatf("done c%0d", c),     done,     e_done[c]);
            check($sformatf("busy c%0d", c),     busy,     e_busy[c]);
            check($sformatf("state c%0d", c),    state,    e_state[c]);
            check($sformatf("layer_cfg c%0d", c), layer_cfg, e_cfg[c]);
            if (c >= 1) check($sformatf("layer_idx c%0d", c), layer_idx, e_lidx[c]);
        end
        last_cfg  = e_cfg[len-1];
        last_lidx = e_lidx[len-1];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rd_en"},     rd_en,     1'b0);
        check({tag, " rd_addr"},   rd_addr,   '0);
        check({tag, " pu_start"},  pu_start,  '0);
        check({tag, " done"},      done,      1'b0);
        check({tag, " busy"},      busy,      1'b0);
        check({tag, " layer_idx"}, layer_idx, '0);
        check({tag, " layer_cfg"}, layer_cfg, '0);
        check({tag, " state"},     state,     3'd0);
    endtask

    initial begin
        int a, n;
        rst = 1'b1; start = 0; abort = 0; num_layers = '0; rd_data = '0; pu_done = '0;
        last_cfg = '0; last_lidx = 0; fin = 0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: three layers, all PUs done 5 cycles after their start
        set_mem(0, 4'hF); set_mem(1, 4'h3); set_mem(2, 4'h8);
        build(3, 0);
        execute(3, fin + 3, -1, 1'b0);

        // 2: empty run
        build(0, 0);
        execute(0, fin + 3, -1, 1'b0);

        // 3: staggered done pulses plus repeated bit 0
        set_mem(0, 4'hF); set_mem(1, 4'hF);
        build(2, 2);
        execute(2, fin + 3, -1, 1'b0);

        // 4: zero-mask layer between two 0x5 layers
        set_mem(0, 4'h5); set_mem(1, 4'h0); set_mem(2, 4'h5);
        build(3, 0);
        execute(3, fin + 3, -1, 1'b0);

        // 5: abort in WAIT of layer 1 of 4, then a fresh run from layer 0
        set_mem(0, 4'hF); set_mem(1, 4'h3); set_mem(2, 4'h5); set_mem(3, 4'h9);
        build(4, 0);
        a = iss_at[1] + 2;
        apply_abort(a);
        execute(4, a + 3, a, 1'b0);
        set_mem(0, 4'h6); set_mem(1, 4'h1);
        build(2, 1);
        execute(2, fin + 3, -1, 1'b1);

        // start together with abort in IDLE, then abort alone: no effect
        @(negedge clk);
        start = 1; abort = 1; num_layers = LPW'(3);
        #1;
        check("idle abort busy", busy, 1'b0);
        @(negedge clk);
        start = 0; abort = 1;
        #1;
        check("idle abort state", state, 3'd0);
        check("idle abort lidx", layer_idx, LPW'(last_lidx));
        @(negedge clk);
        abort = 0;
        #1;
        check("idle abort state2", state, 3'd0);
        check("idle abort cfg", layer_cfg, last_cfg);

        // Random runs, some aborted at a random point
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 6);
            for (int l = 0; l < n; l++) begin
                logic [3:0] mk;
                mk = 4'($urandom());
                if ($urandom_range(0, 3) == 0) mk = 4'h0;
                set_mem(l, mk);
            end
            build(n, 1);
            if (r % 3 == 2) begin
                a = $urandom_range(1, fin);
                apply_abort(a);
                execute(n, a + 3, a, 1'b1);
            end else begin
                execute(n, fin + 3, -1, 1'b1);
            end
        end

        // 6: asynchronous reset between edges while in WAIT
        set_mem(0, 4'hF); set_mem(1, 4'h2);
        build(2, 0);
        execute(2, iss_at[0] + 3, -1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        start = 1; num_layers = LPW'(2);
        #1;
        check("reset start ignored", busy, 1'b0);
        @(negedge clk);
        start = 0; pu_done = '0; rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("post reset");
        last_cfg = '0;

        // Recovery run after reset
        set_mem(0, 4'hA); set_mem(1, 4'h4);
        build(2, 1);
        execute(2, fin + 3, -1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
